pid_seq: RTL and testbench

PID_SEQ -- requirements
Module: pid_seq

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_dbnc.sv | 29 ++
 rtl/pid_seq.sv | 112 +++++++++++
 tb/tb_pid_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state encoding and default timing constants for pid_seq
package seg_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_RIDER = 3'd1,
    SOFT_START = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } pid_seq_state_t;

  localparam int ON_DBNC_DEF  = 1024;
  localparam int OFF_DBNC_DEF = 4096;
  localparam int WDOG_CYC_DEF = 65536;

  // States in which the PID datapath is live (soft-start ramp or full balance)
  function automatic logic is_active(input pid_seq_state_t s);
    return (s == SOFT_START) || (s == RUN);
  endfunction

endpackage

// File: rtl/seg_dbnc.sv
// rtl/seg_dbnc.sv - saturating consecutive-level counter; done when the current
// cycle completes THRESH consecutive cycles of level=1
module seg_dbnc #(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic level,
  output logic done
);

  localparam int            W    = $clog2(THRESH + 1);
  localparam logic [W-1:0]  LAST = W'(THRESH - 1);
  localparam logic [W-1:0]  TOP  = W'(THRESH);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || !level) begin
      cnt <= '0;
    end else if (cnt != TOP) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational so the owning FSM can move on the edge that ends the last cycle
  assign done = level && (cnt >= LAST);

endmodule

// File: rtl/pid_seq.sv
// rtl/pid_seq.sv - segway power/rider sequencer feeding the PID datapath.
// Optional vld watchdog enabled by defining PID_SEQ_WDOG_EN.
module pid_seq
  import seg_pkg::*;
#(
  parameter int ON_DBNC  = ON_DBNC_DEF,
  parameter int OFF_DBNC = OFF_DBNC_DEF,
  parameter int WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_req,
  input  logic       batt_low,
  input  logic       rider_present,
  input  logic       vld,
  input  logic [7:0] ss_tmr,
  output logic       pwr_up,
  output logic       rider_off,
  output logic       pid_vld,
  output logic       fault,
  output logic [2:0] state
);

  pid_seq_state_t state_q, state_d;
  logic           entering;
  logic           on_done, off_done;
  logic           wdog_trip;
  logic           fault_cond;

  assign entering = (state_d != state_q);

  seg_dbnc #(.THRESH(ON_DBNC)) u_on_dbnc (
    .clk   (clk),
    .clr   (rst || entering || (state_q != WAIT_RIDER)),
    .level (rider_present),
    .done  (on_done)
  );

  seg_dbnc #(.THRESH(OFF_DBNC)) u_off_dbnc (
    .clk   (clk),
    .clr   (rst || entering || !is_active(state_q)),
    .level (!rider_present),
    .done  (off_done)
  );

`ifdef PID_SEQ_WDOG_EN
  localparam int            WW     = $clog2(WDOG_CYC + 1);
  localparam logic [WW-1:0] W_LAST = WW'(WDOG_CYC - 1);
  localparam logic [WW-1:0] W_TOP  = WW'(WDOG_CYC);

  logic [WW-1:0] wdog_cnt;

  always_ff @(posedge clk) begin
    if (rst || entering || vld || !is_active(state_q)) begin
      wdog_cnt <= '0;
    end else if (wdog_cnt != W_TOP) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign wdog_trip = is_active(state_q) && !vld && (wdog_cnt >= W_LAST);
`else
  assign wdog_trip = 1'b0;
`endif

  assign fault_cond = batt_low || wdog_trip;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (pwr_req && !batt_low) state_d = WAIT_RIDER;
    end else if (!pwr_req) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        WAIT_RIDER: if (on_done) state_d = SOFT_START;
        SOFT_START: begin
          if (fault_cond)            state_d = FAULT;
          else if (off_done)         state_d = WAIT_RIDER;
          else if (ss_tmr == 8'hFF)  state_d = RUN;
        end
        RUN: begin
          if (fault_cond)            state_d = FAULT;
          else if (off_done)         state_d = WAIT_RIDER;
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs follow the registered state one cycle later; pid_vld is dropped
  // when the sample coincides with leaving the live states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pwr_up    <= 1'b0;
      rider_off <= 1'b1;
      pid_vld   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwr_up    <= is_active(state_q);
      rider_off <= !is_active(state_q);
      fault     <= (state_q == FAULT);
      pid_vld   <= vld && is_active(state_q) && is_active(state_d);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pid_seq.sv
// tb/tb_pid_seq.sv - self-checking bench for pid_seq with a cycle-level reference model
module tb_pid_seq;

  localparam int ON_N  = 4;
  localparam int OFF_N = 8;
  localparam int WD_N  = 16;

  logic       clk = 1'b0;
  logic       rst, pwr_req, batt_low, rider_present, vld;
  logic [7:0] ss_tmr;
  logic       pwr_up, rider_off, pid_vld, fault;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state as an integer, debounce as run lengths of the input level
  int m_state, on_run, off_run, gap;
  bit m_pwr_up, m_rider_off, m_pid_vld, m_fault;

  pid_seq #(.ON_DBNC(ON_N), .OFF_DBNC(OFF_N), .WDOG_CYC(WD_N)) dut (
    .clk(clk), .rst(rst), .pwr_req(pwr_req), .batt_low(batt_low),
    .rider_present(rider_present), .vld(vld), .ss_tmr(ss_tmr),
    .pwr_up(pwr_up), .rider_off(rider_off), .pid_vld(pid_vld),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit live(int s);
    return (s == 2) || (s == 3);
  endfunction

  task automatic model_step();
    int nxt, on_n, off_n, gap_n;
    bit trip;
    if (rst) begin
      m_state = 0; m_pwr_up = 0; m_rider_off = 1; m_pid_vld = 0; m_fault = 0;
      on_run = 0; off_run = 0; gap = 0;
      return;
    end
    on_n  = (m_state == 1 && rider_present) ? on_run + 1 : 0;
    off_n = (live(m_state) && !rider_present) ? off_run + 1 : 0;
    gap_n = (live(m_state) && !vld) ? gap + 1 : 0;
`ifdef PID_SEQ_WDOG_EN
    trip = (gap_n >= WD_N);
`else
    trip = 1'b0;
`endif
    nxt = m_state;
    if (m_state == 0) begin
      if (pwr_req && !batt_low) nxt = 1;
    end else if (!pwr_req) nxt = 0;
    else if (m_state == 1) begin
      if (on_n >= ON_N) nxt = 2;
    end else if (live(m_state)) begin
      if (batt_low || trip) nxt = 4;
      else if (off_n >= OFF_N) nxt = 1;
      else if (m_state == 2 && ss_tmr == 8'hFF) nxt = 3;
    end
    m_pwr_up = live(m_state);
    m_rider_off = !live(m_state);
    m_fault = (m_state == 4);
    m_pid_vld = vld && live(m_state) && live(nxt);
    if (nxt != m_state) begin on_n = 0; off_n = 0; gap_n = 0; end
    m_state = nxt; on_run = on_n; off_run = off_n; gap = gap_n;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_run();
    pwr_req = 0; batt_low = 0; rider_present = 1; ss_tmr = 8'h00; vld = 0;
    tick();
    pwr_req = 1;
    tick();
    repeat (ON_N) tick();
    ss_tmr = 8'hFF;
    tick();
    ss_tmr = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1; pwr_req = 0; batt_low = 0; rider_present = 0; vld = 0; ss_tmr = 8'h00;
    tick(); tick();
    rst = 0;
    n_checks++; if ({state, pwr_up, rider_off, pid_vld, fault} !== {3'd0, 4'b0100}) begin
      n_errors++; $display("FAIL reset_init outs=%b exp=%b", {state, pwr_up, rider_off, pid_vld, fault}, {3'd0, 4'b0100}); end
    go_run();
    n_checks++; if (state !== 3'd3) begin n_errors++; $display("FAIL reset_pre_run state=%0d exp=3", state); end
    rst = 1;
    tick();
    n_checks++; if ({state, pwr_up, rider_off, fault} !== {3'd0, 3'b010}) begin
      n_errors++; $display("FAIL reset_from_run outs=%b exp=%b", {state, pwr_up, rider_off, fault}, {3'd0, 3'b010}); end
    tick();
    rst = 0;
  endtask

  task automatic test_power_up();
    int s, guard;
    pwr_req = 0; rider_present = 1; batt_low = 0; ss_tmr = 8'h00; vld = 0;
    tick();
    n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL pu_idle state=%0d exp=0", state); end
    pwr_req = 1;
    tick();
    n_checks++; if (state !== 3'd1) begin n_errors++; $display("FAIL pu_wait state=%0d exp=1", state); end
    repeat (ON_N - 1) tick();
    rider_present = 0;
    tick();
    rider_present = 1;
    repeat (ON_N - 1) tick();
    n_checks++; if (state !== 3'd1) begin n_errors++; $display("FAIL pu_glitch_clears state=%0d exp=1", state); end
    tick();
    n_checks++; if (state !== 3'd2 || pwr_up !== 1'b0) begin
      n_errors++; $display("FAIL pu_ss_entry state=%0d pwr_up=%b exp=2/0", state, pwr_up); end
    s = 0; guard = 0;
    while (s < 255 && guard < 20) begin
      s = s + $urandom_range(30, 90);
      if (s > 255) s = 255;
      ss_tmr = s[7:0];
      vld = $urandom_range(0, 1);
      tick();
      guard++;
      n_checks++; if (pwr_up !== 1'b1 || state !== ((s == 255) ? 3'd3 : 3'd2) || pid_vld !== m_pid_vld) begin
        n_errors++; $display("FAIL pu_ramp tmr=%0d state=%0d pwr_up=%b pid_vld=%b exp_pid_vld=%b", s, state, pwr_up, pid_vld, m_pid_vld); end
    end
    vld = 0; ss_tmr = 8'h00;
  endtask

  task automatic test_debounce();
    go_run();
    rider_present = 0;
    for (int i = 0; i < OFF_N - 1; i++) begin vld = ~vld; tick(); end
    n_checks++; if (state !== 3'd3) begin n_errors++; $display("FAIL dbnc_7_low state=%0d exp=3", state); end
    rider_present = 1; vld = ~vld;
    tick();
    n_checks++; if (state !== 3'd3 || pid_vld !== m_pid_vld) begin
      n_errors++; $display("FAIL dbnc_restore state=%0d pid_vld=%b exp=3/%b", state, pid_vld, m_pid_vld); end
    rider_present = 0; vld = 0;
    for (int i = 0; i < OFF_N - 1; i++) begin vld = ~vld; tick(); end
    n_checks++; if (state !== 3'd3) begin n_errors++; $display("FAIL dbnc_7_again state=%0d exp=3", state); end
    vld = 1;
    tick();
    n_checks++; if (state !== 3'd1 || pid_vld !== 1'b0) begin
      n_errors++; $display("FAIL dbnc_8_low state=%0d pid_vld=%b exp=1/0", state, pid_vld); end
    vld = 0;
    tick();
    n_checks++; if (rider_off !== 1'b1 || pwr_up !== 1'b0) begin
      n_errors++; $display("FAIL dbnc_rider_off rider_off=%b pwr_up=%b exp=1/0", rider_off, pwr_up); end
  endtask

  task automatic test_batt_fault();
    go_run();
    batt_low = 1;
    tick();
    n_checks++; if (state !== 3'd4) begin n_errors++; $display("FAIL batt_to_fault state=%0d exp=4", state); end
    batt_low = $urandom_range(0, 1);
    tick();
    n_checks++; if (fault !== 1'b1 || rider_off !== 1'b1 || pwr_up !== 1'b0) begin
      n_errors++; $display("FAIL batt_fault_outs fault=%b rider_off=%b pwr_up=%b exp=1/1/0", fault, rider_off, pwr_up); end
    for (int i = 0; i < 6; i++) begin
      rider_present = $urandom_range(0, 1); batt_low = $urandom_range(0, 1); vld = $urandom_range(0, 1);
      tick();
    end
    n_checks++; if (state !== 3'd4 || pid_vld !== 1'b0) begin
      n_errors++; $display("FAIL batt_hold state=%0d pid_vld=%b exp=4/0", state, pid_vld); end
    pwr_req = 0; batt_low = 0; vld = 0;
    tick();
    n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL batt_exit state=%0d exp=0", state); end
    tick();
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL batt_fault_clr fault=%b exp=0", fault); end
  endtask

  task automatic test_priority();
    go_run();
    pwr_req = 0; batt_low = 1;
    tick();
    n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL prio_idle state=%0d exp=0", state); end
    batt_low = 0;
    tick();
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL prio_no_fault fault=%b exp=0", fault); end
  endtask

`ifdef PID_SEQ_WDOG_EN
  task automatic test_watchdog();
    go_run();
    vld = 0;
    repeat (WD_N - 1) tick();
    n_checks++; if (state !== 3'd3) begin n_errors++; $display("FAIL wdog_15 state=%0d exp=3", state); end
    tick();
    n_checks++; if (state !== 3'd4) begin n_errors++; $display("FAIL wdog_trip state=%0d exp=4", state); end
    go_run();
    for (int i = 0; i < 60; i++) begin
      vld = ((i % 15) == 14);
      tick();
      n_checks++; if (state !== 3'd3 || pid_vld !== ((i % 15) == 14)) begin
        n_errors++; $display("FAIL wdog_fed i=%0d state=%0d pid_vld=%b", i, state, pid_vld); end
    end
    vld = 0;
  endtask
`else
  task automatic test_no_watchdog();
    go_run();
    vld = 0;
    repeat (40) tick();
    n_checks++; if (state !== 3'd3) begin n_errors++; $display("FAIL nowdog_run state=%0d exp=3", state); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      pwr_req = ($urandom_range(0, 99) != 0);
      batt_low = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) rider_present = ~rider_present;
      vld = ($urandom_range(0, 2) == 0);
      ss_tmr = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      tick();
      n_checks++; if ({state, pwr_up, rider_off, pid_vld, fault} !== {m_state[2:0], m_pwr_up, m_rider_off, m_pid_vld, m_fault}) begin
        n_errors++; $display("FAIL random cyc=%0d outs=%b exp=%b", i, {state, pwr_up, rider_off, pid_vld, fault},
                             {m_state[2:0], m_pwr_up, m_rider_off, m_pid_vld, m_fault}); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_debounce();
    test_batt_fault();
    test_priority();
`ifdef PID_SEQ_WDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
